// File: rtl/kb_ctrl_pkg.sv
// Shared encodings and constants for the keyboard interrupt controller.
package kb_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned DATA_W  = 8;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t POP     = 3'd1;
    localparam state_t SETTLE  = 3'd2;
    localparam state_t IRQ     = 3'd3;
    localparam state_t RELEASE = 3'd4;

    localparam logic [DATA_W-1:0] ASCII_NONE = 8'h00;
    localparam logic [DATA_W-1:0] DROP_MAX   = 8'hFF;

    // Increment that sticks at DROP_MAX instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == DROP_MAX) ? v : v + DATA_W'(1);
    endfunction

endpackage

// File: rtl/kb_ctrl_timer.sv
// Loadable down-counter shared by the settle and acknowledge windows.
module kb_ctrl_timer #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_value;

    // Load has priority; the caller gates i_en so the count never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_en) begin
            r_value <= r_value - CNT_W'(1);
        end
    end

    assign o_value  = r_value;
    assign o_zero_c = (r_value == '0);

endmodule

// File: rtl/kb_irq_ctrl.sv
// One-character-at-a-time scheduler between the scan-code FIFO and the CPU.
module kb_irq_ctrl
    import kb_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3000,
    parameter int unsigned ACK_TIMEOUT   = 1000000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_kb_buf_empty,
    input  logic [DATA_W-1:0] i_key_code,
    output logic              o_rd_key_code,
    output logic [DATA_W-1:0] o_scan_code,
    input  logic [DATA_W-1:0] i_ascii_in,
    output logic [DATA_W-1:0] o_ascii_code,
    output logic              o_char_valid,
    output logic              o_interrupt,
    input  logic              i_int_ack,
    input  logic              i_clr_status,
    output logic              o_overrun,
    output logic [DATA_W-1:0] o_drop_count
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LOAD    = CNT_W'(ACK_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_pop_req;
    logic              w_in_pop;
    logic              w_accept;
    logic              w_drop;
    logic              w_ack_hit;
    logic              w_timeout;

    logic              w_tmr_load;
    logic              w_tmr_en;
    logic              w_tmr_zero;
    logic [CNT_W-1:0]  w_tmr_load_val;
    logic [CNT_W-1:0]  w_tmr_value;

    logic              r_rd_key_code;
    logic [DATA_W-1:0] r_scan_code;
    logic [DATA_W-1:0] r_ascii_code;
    logic              r_char_valid;
    logic              r_interrupt;
    logic              r_overrun;
    logic [DATA_W-1:0] r_drop_count;

    kb_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_en       (w_tmr_en),
        .i_load_val (w_tmr_load_val),
        .o_value    (w_tmr_value),
        .o_zero_c   (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; ack beats timeout in IRQ.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!i_kb_buf_empty) w_state_nxt = POP;
            POP:     w_state_nxt = SETTLE;
            SETTLE:  if (w_tmr_zero) w_state_nxt = (i_ascii_in == ASCII_NONE) ? IDLE : IRQ;
            IRQ: begin
                if (i_int_ack)       w_state_nxt = RELEASE;
                else if (w_tmr_zero) w_state_nxt = IDLE;
            end
            RELEASE: if (!i_int_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-state control strobes and timer steering.
    always_comb begin
        w_pop_req      = 1'b0;
        w_in_pop       = 1'b0;
        w_accept       = 1'b0;
        w_drop         = 1'b0;
        w_ack_hit      = 1'b0;
        w_timeout      = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_en       = 1'b0;
        w_tmr_load_val = SETTLE_LOAD;
        case (r_state)
            IDLE: w_pop_req = !i_kb_buf_empty;
            POP: begin
                w_in_pop   = 1'b1;
                w_tmr_load = 1'b1;
            end
            SETTLE: begin
                w_tmr_en = (w_tmr_value != '0);
                if (w_tmr_zero) begin
                    w_accept = (i_ascii_in != ASCII_NONE);
                    w_drop   = (i_ascii_in == ASCII_NONE);
                end
                if (w_accept) begin
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = ACK_LOAD;
                end
            end
            IRQ: begin
                w_tmr_en  = (w_tmr_value != '0);
                w_ack_hit = i_int_ack;
                w_timeout = w_tmr_zero && !i_int_ack;
            end
            default: ;
        endcase
    end

    // FIFO pop strobe: high for the single POP cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_key_code <= 1'b0;
        end else begin
            r_rd_key_code <= w_pop_req;
        end
    end

    // Scan code latched as the FIFO pops, held otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_code <= '0;
        end else if (w_in_pop) begin
            r_scan_code <= i_key_code;
        end
    end

    // Character, valid flag and interrupt level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ascii_code <= '0;
            r_char_valid <= 1'b0;
            r_interrupt  <= 1'b0;
        end else begin
            if (w_in_pop) begin
                r_char_valid <= 1'b0;
            end
            if (w_accept) begin
                r_ascii_code <= i_ascii_in;
                r_char_valid <= 1'b1;
                r_interrupt  <= 1'b1;
            end
            if (w_ack_hit || w_timeout) begin
                r_interrupt <= 1'b0;
            end
        end
    end

    // Sticky status; a coincident clear takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else if (i_clr_status) begin
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_timeout) begin
                r_overrun <= 1'b1;
            end
            if (w_drop) begin
                r_drop_count <= sat_inc(r_drop_count);
            end
        end
    end

    assign o_rd_key_code = r_rd_key_code;
    assign o_scan_code   = r_scan_code;
    assign o_ascii_code  = r_ascii_code;
    assign o_char_valid  = r_char_valid;
    assign o_interrupt   = r_interrupt;
    assign o_overrun     = r_overrun;
    assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_kb_irq_ctrl.sv
// Scoreboard bench for kb_irq_ctrl with a FIFO model and a scan-to-ASCII table model.
module tb_kb_irq_ctrl;

    localparam int unsigned S  = 4;
    localparam int unsigned A  = 16;
    localparam int unsigned CW = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       kb_buf_empty;
    logic [7:0] key_code;
    logic       rd_key_code;
    logic [7:0] scan_code;
    logic [7:0] ascii_in;
    logic [7:0] ascii_code;
    logic       char_valid;
    logic       interrupt;
    logic       int_ack;
    logic       clr_status;
    logic       overrun;
    logic [7:0] drop_count;

    always #5 clk = ~clk;

    kb_irq_ctrl #(
        .SETTLE_CYCLES (S),
        .ACK_TIMEOUT   (A),
        .CNT_W         (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_kb_buf_empty (kb_buf_empty),
        .i_key_code     (key_code),
        .o_rd_key_code  (rd_key_code),
        .o_scan_code    (scan_code),
        .i_ascii_in     (ascii_in),
        .o_ascii_code   (ascii_code),
        .o_char_valid   (char_valid),
        .o_interrupt    (interrupt),
        .i_int_ack      (int_ack),
        .i_clr_status   (clr_status),
        .o_overrun      (overrun),
        .o_drop_count   (drop_count)
    );

    function automatic logic [7:0] amap(input logic [7:0] c);
        case (c)
            8'h1C:   return 8'h61;
            8'h32:   return 8'h62;
            default: return 8'h00;
        endcase
    endfunction

    assign ascii_in = amap(scan_code);

    logic [7:0] fifo[$];
    logic [7:0] exp_q[$];
    int         rd_cyc_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc_n = 0;
    int         irq_cnt = 0;
    int         rd_cnt = 0;
    int         last_irq_cyc = 0;
    int         last_rd_cyc = 0;
    bit         pend_pop = 1'b0;
    bit         prev_rd = 1'b0;
    bit         prev_int = 1'b0;
    int         t0, f, r, r2, rc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic refresh();
        kb_buf_empty = (fifo.size() == 0);
        key_code     = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] code);
        fifo.push_back(code);
        if (amap(code) != 8'h00) exp_q.push_back(amap(code));
        refresh();
    endtask

    // One clock: FIFO pop model, pop-strobe and interrupt monitors, scoreboard compare.
    task automatic step();
        @(posedge clk);
        #1;
        cyc_n++;
        if (pend_pop) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pend_pop = 1'b0;
            refresh();
        end
        if (rd_key_code) begin
            check_eq("rd_pulse_width", 32'(prev_rd), 0);
            rd_cnt++;
            last_rd_cyc = cyc_n;
            rd_cyc_q.push_back(cyc_n);
            pend_pop = 1'b1;
        end
        if (interrupt && !prev_int) begin
            irq_cnt++;
            last_irq_cyc = cyc_n;
            check_eq("irq_has_pending_char", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check_eq("irq_ascii_code", 32'(ascii_code), 32'(exp_q.pop_front()));
                check_eq("irq_char_valid", 32'(char_valid), 1);
            end
        end
        prev_rd  = rd_key_code;
        prev_int = interrupt;
    endtask

    task automatic wait_irq(input int max, input string tag);
        int s = irq_cnt;
        int n = 0;
        while (irq_cnt == s && n < max) begin
            step();
            n++;
        end
        check_eq(tag, 32'(irq_cnt != s), 1);
    endtask

    task automatic wait_rd(input int max, input string tag);
        int s = rd_cnt;
        int n = 0;
        while (rd_cnt == s && n < max) begin
            step();
            n++;
        end
        check_eq(tag, 32'(rd_cnt != s), 1);
    endtask

    task automatic ack_char();
        int_ack = 1'b1;
        step();
        check_eq("ack_drops_irq", 32'(interrupt), 0);
        int_ack = 1'b0;
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_interrupt"},  32'(interrupt), 0);
        check_eq({tag, "_rd"},         32'(rd_key_code), 0);
        check_eq({tag, "_char_valid"}, 32'(char_valid), 0);
        check_eq({tag, "_ascii_code"}, 32'(ascii_code), 0);
        check_eq({tag, "_scan_code"},  32'(scan_code), 0);
        check_eq({tag, "_overrun"},    32'(overrun), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        int_ack    = 1'b0;
        clr_status = 1'b0;
        refresh();
        repeat (3) step();
        check_reset_outputs("reset");
        check_eq("reset_drop_count", 32'(drop_count), 0);
        rst_n = 1'b1;
        step();

        // Single mapped key
        t0 = cyc_n;
        push(8'h1C);
        wait_irq(40, "s1_irq_seen");
        check_eq("s1_rd_latency", 32'(last_rd_cyc - t0), 1);
        check_eq("s1_irq_latency", 32'(last_irq_cyc - t0), 32'(S + 2));
        check_eq("s1_one_pop", 32'(rd_cnt), 1);
        repeat (3) step();
        check_eq("s1_irq_held", 32'(interrupt), 1);
        ack_char();

        // Unmapped code followed by a mapped one
        rd_cyc_q.delete();
        push(8'hF0);
        push(8'h1C);
        wait_irq(60, "s2_irq_seen");
        check_eq("s2_two_pops", 32'(rd_cyc_q.size()), 2);
        if (rd_cyc_q.size() == 2) begin
            check_eq("s2_next_pop_gap", 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'(S + 2));
            check_eq("s2_irq_from_second", 32'(last_irq_cyc - rd_cyc_q[1]), 32'(S + 1));
        end
        check_eq("s2_drop_count", 32'(drop_count), 1);
        ack_char();

        // Back-to-back with a long ack on the first character
        rd_cyc_q.delete();
        push(8'h1C);
        push(8'h32);
        wait_irq(40, "s3_irq1_seen");
        int_ack = 1'b1;
        repeat (10) step();
        check_eq("s3_no_pop_during_ack", 32'(rd_cyc_q.size()), 1);
        check_eq("s3_irq_low_during_ack", 32'(interrupt), 0);
        int_ack = 1'b0;
        f = cyc_n;
        wait_irq(40, "s3_irq2_seen");
        check_eq("s3_pop_after_release", 32'(last_rd_cyc - f), 2);
        ack_char();

        // Ack timeout, overrun and clear, then ack on the last cycle
        push(8'h1C);
        push(8'h1C);
        wait_irq(40, "s4_irq1_seen");
        r = last_irq_cyc;
        repeat (A - 1) step();
        check_eq("s4_irq_before_timeout", 32'(interrupt), 1);
        step();
        check_eq("s4_irq_after_timeout", 32'(interrupt), 0);
        check_eq("s4_overrun_set", 32'(overrun), 1);
        check_eq("s4_char_valid_kept", 32'(char_valid), 1);
        step();
        check_eq("s4_next_pop", 32'(last_rd_cyc - r), 32'(A + 1));
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check_eq("s4_overrun_cleared", 32'(overrun), 0);
        wait_irq(40, "s4_irq2_seen");
        r2 = last_irq_cyc;
        repeat (A - 1) step();
        int_ack = 1'b1;
        step();
        check_eq("s4_late_ack_irq", 32'(interrupt), 0);
        check_eq("s4_late_ack_no_overrun", 32'(overrun), 0);
        check_eq("s4_late_ack_window", 32'(cyc_n - r2), 32'(A));
        int_ack = 1'b0;
        step();
        step();

        // Drop-count saturation and clear priority
        rc = irq_cnt;
        for (int i = 0; i < 260; i++) push(8'hF0);
        for (int n = 0; n < 3000 && fifo.size() > 0; n++) step();
        check_eq("s5_fifo_drained", 32'(fifo.size()), 0);
        repeat (S + 4) step();
        check_eq("s5_drop_saturated", 32'(drop_count), 255);
        check_eq("s5_no_irq", 32'(irq_cnt - rc), 0);
        for (int k = 0; k < 2; k++) begin
            push(8'hF0);
            wait_rd(10, "s5_clr_pop");
            repeat (S) step();
            clr_status = 1'b1;
            step();
            clr_status = 1'b0;
            check_eq("s5_clear_wins", 32'(drop_count), 0);
        end
        push(8'hF0);
        repeat (S + 4) step();
        check_eq("s5_count_after_clear", 32'(drop_count), 1);

        // Asynchronous reset mid-SETTLE
        push(8'h1C);
        wait_rd(10, "s6_pop");
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_settle");
        exp_q.delete();
        push(8'h1C);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("rst_no_early_pop", 32'(rd_key_code), 0);
        wait_irq(40, "s6_irq_after_reset");

        // Asynchronous reset mid-IRQ
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_irq");
        exp_q.delete();
        step();
        rst_n = 1'b1;
        rc = rd_cnt;
        repeat (4) step();
        check_eq("rst_irq_stays_low", 32'(interrupt), 0);
        check_eq("rst_no_pop_when_empty", 32'(rd_cnt - rc), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kb_irq_ctrl.md
Name: kb_irq_ctrl

Overview:
Sequencing controller between the PS/2 scan-code FIFO (kb_code) and the processor. It pops one scan code at a time from the FIFO and presents it to the combinational scan-to-ASCII table. After a settle delay it samples the ASCII result. It drops unmapped codes, raises a level interrupt for valid characters, and holds the character until the processor acknowledges. This replaces free-running interrupt counting with a handshaked, one-character-at-a-time scheduler.

Parameters:
SETTLE_CYCLES, 3000, cycles scan_code is held stable before ascii_in is sampled (min 1).
ACK_TIMEOUT, 1000000, cycles interrupt may stay high without int_ack before the character is abandoned (min 1).
CNT_W, 20, timer width; must hold max(SETTLE_CYCLES, ACK_TIMEOUT).

Ports:
clk  in  1  system clock, all logic on rising edge.
Reset  in  1  asynchronous, active-low reset.
kb_buf_empty  in  1  FIFO empty flag from kb_code.
key_code  in  8  FIFO head; valid while kb_buf_empty=0.
rd_key_code  out  1  one-cycle FIFO pop strobe.
scan_code  out  8  latched scan code driven to ASCII table.
ascii_in  in  8  ASCII table result for scan_code; 8'h00 = unmapped.
ascii_code  out  8  last accepted character, held.
char_valid  out  1  high from interrupt assertion until the next pop.
interrupt  out  1  level interrupt to processor.
int_ack  in  1  processor acknowledge, level.
clr_status  in  1  clears overrun and drop_count.
overrun  out  1  sticky: a character timed out unacknowledged.
drop_count  out  8  saturating count of unmapped codes discarded.

Behaviour:
- Reset (Reset=0, async): state IDLE; all outputs 0; timer 0. A scan code already popped is lost. No pop happens in the first cycle after release.
- FSM states: IDLE, POP, SETTLE, IRQ, RELEASE.
- IDLE: if kb_buf_empty=0, go to POP. Otherwise stay.
- POP: rd_key_code=1 for exactly this cycle. scan_reg<=key_code on the same edge. Timer loads SETTLE_CYCLES-1. char_valid<=0. Go to SETTLE.
- SETTLE: scan_code=scan_reg, stable. Timer decrements each cycle. When timer=0, sample ascii_in:
  - ascii_in=8'h00: drop_count+1, saturating at 255; go to IDLE.
  - Otherwise: ascii_code<=ascii_in, char_valid<=1, interrupt<=1, timer loads ACK_TIMEOUT-1; go to IRQ.
- SETTLE lasts exactly SETTLE_CYCLES cycles.
- Latency: kb_buf_empty seen low in IDLE at cycle t; rd_key_code high at t+1; interrupt high at t+2+SETTLE_CYCLES.
- IRQ: interrupt held 1; timer decrements.
  - int_ack=1: interrupt<=0; go to RELEASE.
  - timer=0 with int_ack=0: interrupt<=0, overrun<=1, char_valid stays 1; go to IDLE.
  - int_ack and timeout in the same cycle: the ack wins, no overrun.
- RELEASE: wait for int_ack=0, then go to IDLE. This prevents one long ack from consuming two characters.
- int_ack is ignored outside IRQ and RELEASE.
- At most one outstanding character; the FIFO is never popped while in SETTLE, IRQ or RELEASE.
- scan_code and ascii_code hold their values in every state except at their load edges.
- clr_status: overrun<=0 and drop_count<=0 next cycle. If it coincides with an increment or overrun set, the clear wins.
- Timer is unsigned CNT_W bits and never underflows; the load only occurs on state entry.

Decomposition:
- Package kb_ctrl_pkg: state encoding (3-bit localparams IDLE..RELEASE), ASCII_NONE=8'h00, DROP_MAX=8'hFF.
- One sub-module, kb_ctrl_timer: a loadable CNT_W down-counter with load, enable, value and zero outputs. It is shared by SETTLE and IRQ.

Test Plan:
Use SETTLE_CYCLES=4 and ACK_TIMEOUT=16 for all scenarios.
- Single key: FIFO holds 8'h1C, ascii_in model maps it to 8'h61. Required: rd_key_code high exactly one cycle, interrupt high 6 cycles after empty falls, ascii_code=8'h61, char_valid=1. Ack a few cycles later; interrupt drops on the next edge.
- Unmapped: FIFO holds 8'hF0, ascii_in=8'h00. Required: no interrupt; drop_count=1; controller back in IDLE, and the next FIFO entry pops 2 cycles later.
- Back-to-back: FIFO holds 8'h1C, 8'h32, int_ack held high 10 cycles for the first. Required: the second pop occurs only after int_ack falls; the second interrupt delivers 8'h62.
- Timeout: valid char with no ack. Required: interrupt falls after 16 cycles, overrun=1, next code popped. clr_status then clears overrun; an ack on the 16th cycle instead yields no overrun.
- Saturation: 260 unmapped codes. Required: drop_count=255; clr_status coinciding with a drop gives drop_count=0.
- Reset mid-SETTLE and mid-IRQ: assert Reset=0 asynchronously. Required: interrupt, rd_key_code, char_valid and ascii_code go 0 immediately; no pop in the first cycle after release.
